poly_voice_mixer: RTL and testbench

//  Parametrised polyphonic front end between song_reader and N note_player voices.

---
 rtl/poly_voice_mixer_pkg.sv | 26 ++
 rtl/poly_voice_mixer_voice_allocator.sv | 68 ++++++
 rtl/poly_voice_mixer.sv | 187 ++++++++++++++++++
 tb/tb_poly_voice_mixer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/poly_voice_mixer_pkg.sv
// Shared definitions for the polyphonic voice mixer.
//   mix_state_t : encoding of the mix FSM (IDLE -> COLLECT -> SUM -> OUT)
//   SUM_CNT_W   : width of the SUM-phase voice counter (covers up to 8 voices)
//   lowest_set8 : priority encoder over an 8-bit mask, returns {found, index}
package poly_voice_mixer_pkg;

    typedef enum logic [1:0] {
        MIX_IDLE    = 2'd0,
        MIX_COLLECT = 2'd1,
        MIX_SUM     = 2'd2,
        MIX_OUT     = 2'd3
    } mix_state_t;

    localparam int SUM_CNT_W = 4;

    // Lowest set bit wins; bit 3 of the result flags that any bit was set.
    function automatic logic [3:0] lowest_set8(input logic [7:0] mask);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/poly_voice_mixer_voice_allocator.sv
// Voice allocator for poly_voice_mixer.
// Picks the lowest free voice for a note request, or the voice at the steal
// pointer when every voice is occupied (STEAL=1), or flags a drop (STEAL=0).
// A voice counts as occupied while it reports busy or while it has been handed
// a note that it has not yet acknowledged by raising busy (reserved mask).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   request      : note request this cycle (load_note & play)
//   voice_busy   : per-voice playing status
//   alloc_idx    : chosen voice index, meaningful when alloc_valid
//   alloc_valid  : request will be loaded into alloc_idx
//   alloc_drop   : request is discarded (all occupied, stealing disabled)
module voice_allocator
    import poly_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 3,
    parameter int STEAL      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  request,
    input  logic [NUM_VOICES-1:0] voice_busy,
    output logic [VIDX_W-1:0]     alloc_idx,
    output logic                  alloc_valid,
    output logic                  alloc_drop
);

    logic [NUM_VOICES-1:0] reserved;
    logic [NUM_VOICES-1:0] grant;
    logic [VIDX_W-1:0]     steal_ptr;
    logic [7:0]            free_pad;
    logic [3:0]            enc;
    logic                  found;

    always_comb begin
        free_pad = '0;
        free_pad[NUM_VOICES-1:0] = ~(voice_busy | reserved);
    end

    assign enc         = lowest_set8(free_pad);
    assign found       = enc[3];
    assign alloc_idx   = found ? VIDX_W'(enc[2:0]) : steal_ptr;
    assign alloc_valid = request && (found || (STEAL != 0));
    assign alloc_drop  = request && !found && (STEAL == 0);

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            grant[i] = alloc_valid && (alloc_idx == VIDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reserved  <= '0;
            steal_ptr <= '0;
        end else begin
            // A newly granted voice stays reserved until its busy flag shows up.
            reserved <= (reserved & ~voice_busy) | grant;
            if (request && !found && (STEAL != 0)) begin
                if (steal_ptr == VIDX_W'(NUM_VOICES - 1)) steal_ptr <= '0;
                else                                      steal_ptr <= steal_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_voice_mixer.sv
// Polyphonic front end between song_reader and NUM_VOICES note_player voices.
// Allocation: a note request (load_note & play) is handed to a voice one cycle
// later via a one-hot voice_load pulse with registered note/duration.
// Mixing: generate_next_sample starts a collect phase that latches each voice's
// sample on its ready pulse, then the samples are summed serially, shifted by
// SHIFT and saturated into mix_sample, announced by a mix_ready pulse.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   play, load_note, note, duration: note request from mcu/song_reader
//   note_accepted, dropped_note    : allocation outcome pulses
//   voice_load, voice_note, voice_duration : to note_player voices
//   voice_busy, voice_ready, voice_samples : from note_player voices
//   generate_next_sample           : mix request from codec_conditioner
//   mix_sample, mix_ready          : mixed sample and its update pulse
//   mix_overrun                    : mix request arrived while a mix was running
module poly_voice_mixer
    import poly_voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int SAMPLE_W   = 16,
    parameter int SHIFT      = 2,
    parameter int STEAL      = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           load_note,
    input  logic [NOTE_W-1:0]              note,
    input  logic [DUR_W-1:0]               duration,
    output logic                           note_accepted,
    output logic                           dropped_note,
    output logic [NUM_VOICES-1:0]          voice_load,
    output logic [NOTE_W-1:0]              voice_note,
    output logic [DUR_W-1:0]               voice_duration,
    input  logic [NUM_VOICES-1:0]          voice_busy,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic                           generate_next_sample,
    output logic [SAMPLE_W-1:0]            mix_sample,
    output logic                           mix_ready,
    output logic                           mix_overrun
);

    localparam int ACC_W = SAMPLE_W + VIDX_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [SAMPLE_W-1:0] shift_saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> SHIFT;
        if (s > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
        else if (s < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
        else                  return s[SAMPLE_W-1:0];
    endfunction

    // ---------------- allocation: request -> registered voice load ----------------
    logic                  request;
    logic [VIDX_W-1:0]     alloc_idx;
    logic                  alloc_valid;
    logic                  alloc_drop;
    logic [NUM_VOICES-1:0] alloc_onehot;

    assign request = load_note & play;

    voice_allocator #(
        .NUM_VOICES (NUM_VOICES),
        .VIDX_W     (VIDX_W),
        .STEAL      (STEAL)
    ) u_alloc (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .voice_busy  (voice_busy),
        .alloc_idx   (alloc_idx),
        .alloc_valid (alloc_valid),
        .alloc_drop  (alloc_drop)
    );

    always_comb begin
        alloc_onehot = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            alloc_onehot[i] = alloc_valid && (alloc_idx == VIDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            voice_load     <= '0;
            note_accepted  <= 1'b0;
            dropped_note   <= 1'b0;
            voice_note     <= '0;
            voice_duration <= '0;
        end else begin
            voice_load    <= alloc_onehot;
            note_accepted <= alloc_valid;
            dropped_note  <= alloc_drop;
            if (alloc_valid) begin
                voice_note     <= note;
                voice_duration <= duration;
            end
        end
    end

    // ---------------- collect: latch samples on their ready pulses ----------------
    mix_state_t                   state;
    logic [NUM_VOICES-1:0]        ready_mask;
    logic [NUM_VOICES-1:0]        mask_next;
    logic signed [SAMPLE_W-1:0]   held [NUM_VOICES];
    logic [SUM_CNT_W-1:0]         sum_cnt;
    logic signed [SAMPLE_W-1:0]   sel_sample;
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_next;

    assign mask_next = ready_mask | voice_ready;

    // Idle voices contribute silence regardless of what is on their sample bus.
    always_ff @(posedge clk) begin
        if (state == MIX_COLLECT) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_ready[i]) begin
                    held[i] <= voice_busy[i] ? voice_samples[i*SAMPLE_W +: SAMPLE_W] : '0;
                end
            end
        end
    end

    // ---------------- sum: one voice per cycle into the accumulator ----------------
    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (sum_cnt == SUM_CNT_W'(i)) sel_sample = held[i];
        end
    end

    assign acc_next = acc + $signed({{(ACC_W - SAMPLE_W){sel_sample[SAMPLE_W-1]}}, sel_sample});

    // ---------------- mix FSM and output register ----------------
    // The final SUM step writes mix_sample directly so that mix_ready is
    // visible during OUT, NUM_VOICES+1 cycles after the mask completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= MIX_IDLE;
            ready_mask  <= '0;
            sum_cnt     <= '0;
            acc         <= '0;
            mix_sample  <= '0;
            mix_ready   <= 1'b0;
            mix_overrun <= 1'b0;
        end else begin
            mix_ready   <= 1'b0;
            mix_overrun <= generate_next_sample && (state != MIX_IDLE);
            case (state)
                MIX_IDLE: begin
                    if (generate_next_sample) begin
                        ready_mask <= '0;
                        state      <= MIX_COLLECT;
                    end
                end
                MIX_COLLECT: begin
                    ready_mask <= mask_next;
                    if (&mask_next) begin
                        sum_cnt <= '0;
                        acc     <= '0;
                        state   <= MIX_SUM;
                    end
                end
                MIX_SUM: begin
                    acc     <= acc_next;
                    sum_cnt <= sum_cnt + 1'b1;
                    if (sum_cnt == SUM_CNT_W'(NUM_VOICES - 1)) begin
                        mix_sample <= shift_saturate(acc_next);
                        mix_ready  <= 1'b1;
                        state      <= MIX_OUT;
                    end
                end
                MIX_OUT: begin
                    state <= MIX_IDLE;
                end
                default: state <= MIX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer. Two instances share all inputs:
//   dut_s : STEAL=1, SHIFT=2
//   dut_d : STEAL=0, SHIFT=0
module tb_poly_voice_mixer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b1;
    logic        load_note = 1'b0;
    logic [5:0]  note = '0;
    logic [5:0]  duration = '0;
    logic [3:0]  voice_busy = '0;
    logic [3:0]  voice_ready = '0;
    logic [63:0] voice_samples = '0;
    logic        gen = 1'b0;

    logic        acc_s, drop_s, rdy_s, ovr_s;
    logic [3:0]  load_s;
    logic [5:0]  vnote_s, vdur_s;
    logic [15:0] mix_s;
    logic        acc_d, drop_d, rdy_d, ovr_d;
    logic [3:0]  load_d;
    logic [5:0]  vnote_d, vdur_d;
    logic [15:0] mix_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    poly_voice_mixer #(.NUM_VOICES(4), .VIDX_W(3), .NOTE_W(6), .DUR_W(6),
                       .SAMPLE_W(16), .SHIFT(2), .STEAL(1)) dut_s (
        .clk(clk), .reset(reset), .play(play), .load_note(load_note),
        .note(note), .duration(duration),
        .note_accepted(acc_s), .dropped_note(drop_s), .voice_load(load_s),
        .voice_note(vnote_s), .voice_duration(vdur_s),
        .voice_busy(voice_busy), .voice_ready(voice_ready), .voice_samples(voice_samples),
        .generate_next_sample(gen), .mix_sample(mix_s), .mix_ready(rdy_s), .mix_overrun(ovr_s)
    );

    poly_voice_mixer #(.NUM_VOICES(4), .VIDX_W(3), .NOTE_W(6), .DUR_W(6),
                       .SAMPLE_W(16), .SHIFT(0), .STEAL(0)) dut_d (
        .clk(clk), .reset(reset), .play(play), .load_note(load_note),
        .note(note), .duration(duration),
        .note_accepted(acc_d), .dropped_note(drop_d), .voice_load(load_d),
        .voice_note(vnote_d), .voice_duration(vdur_d),
        .voice_busy(voice_busy), .voice_ready(voice_ready), .voice_samples(voice_samples),
        .generate_next_sample(gen), .mix_sample(mix_d), .mix_ready(rdy_d), .mix_overrun(ovr_d)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse load_note for one cycle and check both instances one cycle later.
    task automatic send_note(input string tag, input logic [5:0] n, input logic [5:0] d,
                             input logic [3:0] exp_load_s, input logic [3:0] exp_load_d,
                             input logic exp_drop_d);
        @(negedge clk);
        note = n; duration = d; load_note = 1'b1;
        @(posedge clk);
        #1;
        check_val({tag, " load_s"}, load_s, exp_load_s);
        check_val({tag, " load_d"}, load_d, exp_load_d);
        check_val({tag, " drop_d"}, drop_d, exp_drop_d);
        check_val({tag, " acc_d"}, acc_d, !exp_drop_d);
        if (exp_load_s != 4'd0) begin
            check_val({tag, " acc_s"}, acc_s, 1'b1);
            check_val({tag, " note_s"}, vnote_s, n);
            check_val({tag, " dur_s"}, vdur_s, d);
        end
        @(negedge clk);
        load_note = 1'b0;
    endtask

    // Start a mix, deliver ready pulses in two groups, and measure latency
    // from the cycle of the last ready pulse to mix_ready.
    task automatic run_mix(input string tag, input logic [63:0] smp, input logic [3:0] busy,
                           input logic [15:0] exp_s, input logic [15:0] exp_d);
        int lat;
        lat = 0;
        @(negedge clk);
        voice_busy = busy; voice_samples = smp; gen = 1'b1;
        @(negedge clk);
        gen = 1'b0; voice_ready = 4'b0011;
        @(negedge clk);
        voice_ready = 4'b1100;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rdy_s) begin
                lat = k;
                break;
            end
            @(negedge clk);
            voice_ready = '0;
        end
        voice_ready = '0;
        check_val({tag, " latency"}, lat, 5);
        check_val({tag, " rdy_d"}, rdy_d, 1'b1);
        check_val({tag, " mix_s"}, mix_s, exp_s);
        check_val({tag, " mix_d"}, mix_d, exp_d);
        @(posedge clk);
        #1;
        check_val({tag, " rdy_pulse"}, rdy_s, 1'b0);
        check_val({tag, " hold_s"}, mix_s, exp_s);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst load", {load_s, load_d}, 8'h00);
        check_val("rst acc", {acc_s, acc_d, drop_s, drop_d}, 4'h0);
        check_val("rst mix", {mix_s, mix_d}, 32'h0);
        check_val("rst flags", {rdy_s, rdy_d, ovr_s, ovr_d}, 4'h0);
        check_val("rst vnote", vnote_s, 6'd0);

        // Test 1: idle voices, lowest free voice, reserved until busy rises.
        voice_busy = 4'b0000;
        send_note("t1a", 6'd10, 6'd3, 4'b0001, 4'b0001, 1'b0);
        @(posedge clk); #1;
        check_val("t1 pulse", load_s, 4'b0000);
        repeat (3) @(negedge clk);
        send_note("t1b", 6'd20, 6'd4, 4'b0010, 4'b0010, 1'b0);
        repeat (4) @(negedge clk);
        send_note("t1c", 6'd30, 6'd5, 4'b0100, 4'b0100, 1'b0);

        // play=0 blocks allocation entirely.
        @(negedge clk);
        play = 1'b0; load_note = 1'b1; note = 6'd7;
        @(posedge clk); #1;
        check_val("noplay", {load_s, load_d, acc_s, acc_d, drop_s, drop_d}, 14'h0);
        @(negedge clk);
        load_note = 1'b0; play = 1'b1;

        // Test 2: all busy, stealing wraps the pointer; no-steal instance drops.
        do_reset();
        voice_busy = 4'b1111;
        send_note("t2a", 6'd1, 6'd1, 4'b0001, 4'b0000, 1'b1);
        send_note("t2b", 6'd2, 6'd1, 4'b0010, 4'b0000, 1'b1);
        send_note("t2c", 6'd3, 6'd1, 4'b0100, 4'b0000, 1'b1);
        send_note("t2d", 6'd4, 6'd1, 4'b1000, 4'b0000, 1'b1);
        send_note("t2e", 6'd5, 6'd1, 4'b0001, 4'b0000, 1'b1);

        // Test 3..5: mixing.
        do_reset();
        run_mix("t3", {4{16'h1000}}, 4'b1111, 16'h1000, 16'h4000);
        run_mix("t4p", {4{16'h7FFF}}, 4'b1111, 16'h7FFF, 16'h7FFF);
        run_mix("t4n", {4{16'h8000}}, 4'b1111, 16'h8000, 16'h8000);
        run_mix("t5", {16'h0400, 16'h5A5A, 16'h0400, 16'h0400}, 4'b1011, 16'h0300, 16'h0C00);
        run_mix("tsg", {16'hFFF0, 16'h0050, 16'hFF00, 16'h0100}, 4'b1111, 16'h0010, 16'h0040);

        // Test 6a: generate_next_sample during SUM flags an overrun and is ignored.
        @(negedge clk);
        voice_samples = {4{16'h1000}}; voice_busy = 4'b1111; gen = 1'b1;
        @(negedge clk);
        gen = 1'b0; voice_ready = 4'b1111;
        @(negedge clk);
        voice_ready = 4'b0000; gen = 1'b1;
        @(posedge clk); #1;
        check_val("t6 ovr_s", ovr_s, 1'b1);
        check_val("t6 ovr_d", ovr_d, 1'b1);
        @(negedge clk);
        gen = 1'b0;
        @(posedge clk); #1;
        check_val("t6 ovr_end", ovr_s, 1'b0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (rdy_s) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("t6 done", lat != 0, 1'b1);
        check_val("t6 mix_s", mix_s, 16'h1000);

        // Test 6b: reset during COLLECT abandons the mix and clears mix_sample.
        @(negedge clk);
        gen = 1'b1;
        @(negedge clk);
        gen = 1'b0; voice_ready = 4'b0001;
        @(negedge clk);
        voice_ready = 4'b0000; reset = 1'b1;
        @(posedge clk); #1;
        check_val("t6 rst mix", {mix_s, mix_d}, 32'h0);
        check_val("t6 rst rdy", {rdy_s, rdy_d}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        run_mix("t6c", {4{16'h0400}}, 4'b1111, 16'h0400, 16'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
